// File: rtl/tl_ul_if.sv
// TileLink-UL A/D channel pair bundle. The monitor modport observes every
// signal; master/slave describe the two active ends of the link.
interface tl_ul_if #(
    parameter int ADDR_W     = 30,
    parameter int SRC_W      = 2,
    parameter int SIZE_W     = 3,
    parameter int BEAT_BYTES = 4
);
    // Handshake: a beat transfers on a rising clock edge where valid and ready
    // are both high; once valid rises, the sender holds valid and every payload
    // field unchanged until that transfer edge.
    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [SIZE_W-1:0]     a_size;
    logic [SRC_W-1:0]      a_source;
    logic [ADDR_W-1:0]     a_address;
    logic [BEAT_BYTES-1:0] a_mask;
    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [SIZE_W-1:0]     d_size;
    logic [SRC_W-1:0]      d_source;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_source
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source
    );

    modport monitor (
        input a_valid, a_ready, a_opcode, a_size, a_source, a_address, a_mask,
        input d_valid, d_ready, d_opcode, d_size, d_source
    );
endinterface

// File: rtl/tl_ul_link_monitor.sv
// Passive TileLink-UL checker: per-source in-flight table, burst beat tracking,
// watchdog. Define TL_MON_ASSERT_EN to echo each err_valid pulse as a $error.
module tl_ul_link_monitor #(
    parameter int ADDR_W     = 30,
    parameter int SRC_W      = 2,
    parameter int SIZE_W     = 3,
    parameter int BEAT_BYTES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic           clock,
    input  logic           reset_n,
    tl_ul_if.monitor       bus,
    output logic           err_valid,
    output logic [3:0]     err_code,
    output logic           err_sticky,
    output logic [SRC_W:0] inflight
);
    localparam int N_SRC  = 2 ** SRC_W;
    localparam int BB_LOG = $clog2(BEAT_BYTES);
    localparam int CNT_W  = 2 ** SIZE_W;
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int INF_W  = SRC_W + 1;
    localparam int A_W    = 3 + SIZE_W + SRC_W + ADDR_W + BEAT_BYTES;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    function automatic logic [CNT_W-1:0] beats_of(input logic [SIZE_W-1:0] sz);
        if (int'(sz) <= BB_LOG) return CNT_W'(1);
        return CNT_W'(1) << (int'(sz) - BB_LOG);
    endfunction

    logic                  a_fire, d_fire, a_first, a_is_put, a_legal;
    logic [CNT_W-1:0]      a_cnt, d_cnt, a_burst_beats, d_beats;
    logic                  d_last, d_clear_same;
    logic [2:0]            first_op;
    logic [SRC_W-1:0]      first_src;
    logic [SIZE_W-1:0]     first_size;
    logic [N_SRC-1:0]      tbl_valid, tbl_get;
    logic [SIZE_W-1:0]     tbl_size [N_SRC];
    logic                  stall_q;
    logic [A_W-1:0]        a_bundle, a_hold;
    logic [WD_W-1:0]       wd_cnt;
    logic                  wd_run, wd_hit;
    logic [ADDR_W-1:0]     align_mask;
    logic [BEAT_BYTES-1:0] act_mask;
    int                    lane_off;
    logic [10:1]           viol;
    logic [3:0]            code_nx;

    assign a_fire        = bus.a_valid & bus.a_ready;
    assign d_fire        = bus.d_valid & bus.d_ready;
    assign a_first       = (a_cnt == '0);
    assign a_is_put      = (bus.a_opcode == OP_PUT_FULL) || (bus.a_opcode == OP_PUT_PART);
    assign a_legal       = a_is_put || (bus.a_opcode == OP_GET);
    assign a_burst_beats = a_is_put ? beats_of(bus.a_size) : CNT_W'(1);
    assign d_beats       = (bus.d_opcode == OP_ACK_DATA) ? beats_of(bus.d_size) : CNT_W'(1);
    assign d_last        = (d_cnt == d_beats - CNT_W'(1));
    assign d_clear_same  = d_fire && d_last && (bus.d_source == bus.a_source);
    assign a_bundle      = {bus.a_opcode, bus.a_size, bus.a_source, bus.a_address, bus.a_mask};
    assign align_mask    = (ADDR_W'(1) << bus.a_size) - ADDR_W'(1);
    assign wd_run        = (inflight != '0) && !d_fire;
    assign wd_hit        = wd_run && (wd_cnt == WD_W'(TIMEOUT - 1));

    // Lanes covered by a sub-beat transfer are the naturally aligned group
    // containing the address; transfers of a beat or more cover every lane.
    always_comb begin
        lane_off = int'(bus.a_address & ADDR_W'(BEAT_BYTES - 1));
        act_mask = '0;
        for (int i = 0; i < BEAT_BYTES; i++)
            act_mask[i] = (int'(bus.a_size) >= BB_LOG) ||
                          ((i >> bus.a_size) == (lane_off >> bus.a_size));
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < N_SRC; i++)
            inflight = inflight + INF_W'(tbl_valid[i]);
    end

    always_comb begin
        viol     = '0;
        viol[1]  = a_fire && !a_legal;
        viol[2]  = a_fire && ((bus.a_address & align_mask) != '0);
        viol[3]  = a_fire && (bus.a_opcode == OP_PUT_FULL) && ((bus.a_mask & act_mask) != act_mask);
        viol[4]  = stall_q && (!bus.a_valid || (a_bundle != a_hold));
        viol[5]  = a_fire && a_first && tbl_valid[bus.a_source] && !d_clear_same;
        viol[6]  = a_fire && !a_first && ((bus.a_source != first_src) ||
                   (bus.a_size != first_size) || (bus.a_opcode != first_op));
        viol[7]  = d_fire && !tbl_valid[bus.d_source];
        viol[8]  = d_fire && tbl_valid[bus.d_source] &&
                   (bus.d_opcode != (tbl_get[bus.d_source] ? OP_ACK_DATA : OP_ACK));
        viol[9]  = d_fire && tbl_valid[bus.d_source] && (bus.d_size != tbl_size[bus.d_source]);
        viol[10] = wd_hit;
        code_nx  = '0;
        for (int i = 10; i >= 1; i--)
            if (viol[i]) code_nx = 4'(i);
    end

    // Clear precedes set so a last D beat and a fresh A on one source re-arms the entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tbl_valid <= '0;
            tbl_get   <= '0;
            for (int i = 0; i < N_SRC; i++) tbl_size[i] <= '0;
        end else begin
            if (d_fire && d_last) tbl_valid[bus.d_source] <= 1'b0;
            if (a_fire && a_first) begin
                tbl_valid[bus.a_source] <= 1'b1;
                tbl_get[bus.a_source]   <= !a_is_put;
                tbl_size[bus.a_source]  <= bus.a_size;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_cnt      <= '0;
            first_op   <= '0;
            first_src  <= '0;
            first_size <= '0;
            d_cnt      <= '0;
            stall_q    <= 1'b0;
            a_hold     <= '0;
        end else begin
            if (a_fire) begin
                if (a_first) begin
                    first_op   <= bus.a_opcode;
                    first_src  <= bus.a_source;
                    first_size <= bus.a_size;
                    if (a_burst_beats != CNT_W'(1)) a_cnt <= CNT_W'(1);
                end else if (a_cnt == beats_of(first_size) - CNT_W'(1)) begin
                    a_cnt <= '0;
                end else begin
                    a_cnt <= a_cnt + CNT_W'(1);
                end
            end
            if (d_fire) d_cnt <= d_last ? '0 : d_cnt + CNT_W'(1);
            stall_q <= bus.a_valid & ~bus.a_ready;
            if (bus.a_valid && !bus.a_ready) a_hold <= a_bundle;
        end
    end

    // Watchdog saturates at TIMEOUT so it reports once per stall episode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                      wd_cnt <= '0;
        else if (!wd_run)                  wd_cnt <= '0;
        else if (wd_cnt != WD_W'(TIMEOUT)) wd_cnt <= wd_cnt + WD_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_valid  <= 1'b0;
            err_code   <= '0;
            err_sticky <= 1'b0;
        end else begin
            err_valid  <= (viol != '0);
            err_code   <= code_nx;
            err_sticky <= err_sticky | (viol != '0);
        end
    end

`ifdef TL_MON_ASSERT_EN
    logic [SRC_W-1:0] src_nx, err_src;
    always_comb begin
        src_nx = '0;
        if (code_nx >= 4'd7 && code_nx <= 4'd9)  src_nx = bus.d_source;
        else if (code_nx != '0 && code_nx <= 4'd6) src_nx = bus.a_source;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_src <= '0;
        else          err_src <= src_nx;
    end
    always @(posedge clock)
        if (reset_n && err_valid)
            $error("tl_ul_link_monitor code %0d src %0d", err_code, err_src);
`else
    // Silent build: violations surface only on the err_* ports.
`endif
endmodule

// File: tb/tb_tl_ul_link_monitor.sv
// Directed bench for tl_ul_link_monitor: hand-computed error codes and
// in-flight counts for each protocol scenario, with a short watchdog.
module tb_tl_ul_link_monitor;
  localparam int ADDR_W = 30;
  localparam int SRC_W = 2;
  localparam int SIZE_W = 3;
  localparam int BEAT_BYTES = 4;
  localparam int TIMEOUT = 16;

  logic clock = 1'b0;
  logic reset_n;
  logic err_valid;
  logic [3:0] err_code;
  logic err_sticky;
  logic [SRC_W:0] inflight;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] exp_q[$];

  tl_ul_if #(.ADDR_W(ADDR_W), .SRC_W(SRC_W), .SIZE_W(SIZE_W), .BEAT_BYTES(BEAT_BYTES)) bus ();

  tl_ul_link_monitor #(
    .ADDR_W(ADDR_W), .SRC_W(SRC_W), .SIZE_W(SIZE_W), .BEAT_BYTES(BEAT_BYTES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky), .inflight(inflight)
  );

  // clock / reset
  always #5 clock = ~clock;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_err(input string tag);
    logic [3:0] e;
    e = exp_q.pop_front();
    check({tag, "_valid"}, err_valid, (e != 4'd0));
    check({tag, "_code"}, err_code, e);
  endtask

  // drivers
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic a_drive(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                         input logic [29:0] addr, input logic [3:0] mask);
    bus.a_valid = 1'b1; bus.a_ready = 1'b1; bus.a_opcode = op; bus.a_size = sz;
    bus.a_source = src; bus.a_address = addr; bus.a_mask = mask;
  endtask

  task automatic a_idle();
    bus.a_valid = 1'b0; bus.a_ready = 1'b1;
  endtask

  task automatic d_drive(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src);
    bus.d_valid = 1'b1; bus.d_ready = 1'b1; bus.d_opcode = op; bus.d_size = sz; bus.d_source = src;
  endtask

  task automatic d_idle();
    bus.d_valid = 1'b0; bus.d_ready = 1'b1;
  endtask

  // single-beat A or D followed by an idle setup; returns after the firing edge
  task automatic a_once(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src,
                        input logic [29:0] addr, input logic [3:0] mask);
    a_drive(op, sz, src, addr, mask);
    step();
    a_idle();
  endtask

  task automatic d_once(input logic [2:0] op, input logic [2:0] sz, input logic [1:0] src);
    d_drive(op, sz, src);
    step();
    d_idle();
  endtask

  initial begin
    int pulses;
    int others;
    reset_n = 1'b1;
    a_idle(); d_idle();
    bus.a_opcode = 3'd4; bus.a_size = '0; bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0;
    bus.d_opcode = '0; bus.d_size = '0; bus.d_source = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_err_valid", err_valid, 0);
    check("rst_err_code", err_code, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_inflight", inflight, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Get src0 0x10 size2, AccessAckData three cycles later
    a_once(3'd4, 3'd2, 2'd0, 30'h10, 4'hF);
    exp_q.push_back(0); check_err("get_ok");
    check("get_inflight1", inflight, 1);
    step(); step();
    check("get_inflight_wait", inflight, 1);
    d_once(3'd1, 3'd2, 2'd0);
    exp_q.push_back(0); check_err("ackdata_ok");
    check("get_inflight0", inflight, 0);

    // misaligned Get
    a_once(3'd4, 3'd2, 2'd0, 30'h12, 4'hF);
    exp_q.push_back(2); check_err("misalign");
    step();
    check("misalign_pulse_end", err_valid, 0);
    check("misalign_sticky", err_sticky, 1);
    d_once(3'd1, 3'd2, 2'd0);
    check("misalign_inflight0", inflight, 0);
    check("sticky_holds", err_sticky, 1);

    // address changes while stalled, then accepted unchanged
    a_drive(3'd4, 3'd2, 2'd1, 30'h10, 4'hF);
    bus.a_ready = 1'b0;
    step();
    exp_q.push_back(0); check_err("stall_first");
    bus.a_address = 30'h14;
    step();
    exp_q.push_back(4); check_err("stall_change");
    bus.a_ready = 1'b1;
    step();
    a_idle();
    exp_q.push_back(0); check_err("stall_accept");
    check("stall_inflight", inflight, 1);

    // duplicate source, then wrong D opcode
    a_once(3'd4, 3'd2, 2'd1, 30'h10, 4'hF);
    exp_q.push_back(5); check_err("dup_src");
    d_once(3'd0, 3'd2, 2'd1);
    exp_q.push_back(8); check_err("d_opcode");
    check("d_opcode_inflight", inflight, 0);

    // illegal opcode still tracked as a Get
    a_once(3'd2, 3'd2, 2'd0, 30'h0, 4'hF);
    exp_q.push_back(1); check_err("bad_opcode");
    check("bad_opcode_inflight", inflight, 1);
    d_once(3'd1, 3'd2, 2'd0);
    exp_q.push_back(0); check_err("bad_opcode_ack");

    // PutFull 2 bytes at 0x2 needs lanes 2,3
    a_once(3'd0, 3'd1, 2'd0, 30'h2, 4'h4);
    exp_q.push_back(3); check_err("putfull_mask");
    d_once(3'd0, 3'd1, 2'd0);
    exp_q.push_back(0); check_err("putfull_ack");

    // D for idle source, then d_size mismatch
    d_once(3'd0, 3'd2, 2'd3);
    exp_q.push_back(7); check_err("d_unknown");
    a_once(3'd4, 3'd2, 2'd2, 30'h0, 4'hF);
    d_once(3'd1, 3'd1, 2'd2);
    exp_q.push_back(9); check_err("d_size");
    check("d_size_inflight", inflight, 0);

    // two-beat Put whose second beat switches source
    a_drive(3'd0, 3'd3, 2'd0, 30'h0, 4'hF);
    step();
    exp_q.push_back(0); check_err("burst_b0");
    bus.a_source = 2'd1;
    step();
    a_idle();
    exp_q.push_back(6); check_err("burst_b1");
    check("burst_inflight", inflight, 1);
    d_once(3'd0, 3'd3, 2'd0);
    exp_q.push_back(0); check_err("burst_ack");

    // four-beat Put with no response: single watchdog pulse
    a_drive(3'd0, 3'd4, 2'd3, 30'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_q.push_back(0); check_err("put4_beat");
    end
    a_idle();
    pulses = 0; others = 0;
    for (int i = 0; i < 3 * TIMEOUT; i++) begin
      step();
      if (err_valid && err_code == 4'd10) pulses++;
      else if (err_valid) others++;
    end
    check("wd_pulses", pulses, 1);
    check("wd_others", others, 0);
    check("wd_inflight", inflight, 1);
    d_once(3'd0, 3'd4, 2'd3);
    exp_q.push_back(0); check_err("wd_ack");
    check("wd_ack_inflight", inflight, 0);
    a_once(3'd4, 3'd2, 2'd0, 30'h0, 4'hF);
    pulses = 0;
    for (int i = 0; i < 2 * TIMEOUT; i++) begin
      step();
      if (err_valid && err_code == 4'd10) pulses++;
    end
    check("wd_rearm_pulses", pulses, 1);

    // A and D on different sources in one cycle: src0 out, src1 in
    a_drive(3'd4, 3'd2, 2'd1, 30'h0, 4'hF);
    d_drive(3'd1, 3'd2, 2'd0);
    step();
    a_idle(); d_idle();
    exp_q.push_back(0); check_err("net0");
    check("net0_inflight", inflight, 1);
    d_once(3'd1, 3'd2, 2'd1);
    check("net0_drain", inflight, 0);

    // last D and new A on src2 together
    a_once(3'd4, 3'd2, 2'd2, 30'h20, 4'hF);
    a_drive(3'd4, 3'd2, 2'd2, 30'h24, 4'hF);
    d_drive(3'd1, 3'd2, 2'd2);
    step();
    a_idle(); d_idle();
    exp_q.push_back(0); check_err("same_src_swap");
    check("same_src_inflight", inflight, 1);
    d_once(3'd1, 3'd2, 2'd2);
    check("same_src_drain", inflight, 0);

    // reset mid-burst drops tracking
    a_drive(3'd0, 3'd4, 2'd1, 30'h0, 4'hF);
    step(); step();
    check("pre_rst_inflight", inflight, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_sticky", err_sticky, 0);
    check("mid_rst_inflight", inflight, 0);
    check("mid_rst_err_valid", err_valid, 0);
    a_idle();
    step();
    reset_n = 1'b1;
    d_once(3'd0, 3'd4, 2'd1);
    exp_q.push_back(7); check_err("post_rst_d");
    check("post_rst_sticky", err_sticky, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
